// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR scheduler: LFSR width, default seed,
// the Fibonacci step function and the scheduler state type.
package lfsr_pkg;

    localparam int LFSR_W = 16;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        WARM  = 2'd0,
        SERVE = 2'd1,
        STEP  = 2'd2
    } sched_state_t;

    // One Fibonacci step with taps 16, 14, 13, 11.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
        return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    endfunction

    // Width of a down-counter that must hold both the warm-up and stride counts.
    function automatic int cnt_width(input int warmup, input int stride);
        int cnt_max;
        cnt_max = (warmup > stride) ? warmup : stride;
        return $clog2(cnt_max + 1);
    endfunction

endpackage

// File: rtl/lfsr16_core.sv
// 16-bit Fibonacci LFSR register. A load takes priority over a step; the
// register comes out of reset holding the default non-zero seed.
module lfsr16_core
    import lfsr_pkg::*;
(
    input  logic              clk,
    input  logic              nReset,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    input  logic              step,
    output logic [LFSR_W-1:0] q
);

    // LFSR register: reset, load or advance one step.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            q <= DEFAULT_SEED;
        end else if (load) begin
            q <= load_val;
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/lfsr_scheduler.sv
// Shares one LFSR among N_REQ requesters. Handles seeding, post-seed warm-up,
// per-word stride stepping and round-robin granting of the current word.
module lfsr_scheduler
    import lfsr_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int WARMUP = 16,
    parameter int STRIDE = 1
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              seed_valid,
    input  logic [LFSR_W-1:0] seed,
    output logic              seed_ready,
    input  logic [N_REQ-1:0]  req,
    output logic [N_REQ-1:0]  gnt,
    output logic              data_valid,
    output logic [LFSR_W-1:0] data,
    output logic              busy
);

    localparam int CNT_W = cnt_width(WARMUP, STRIDE);
    localparam int RR_W  = $clog2(N_REQ);

    localparam logic [CNT_W-1:0] WARM_CNT = CNT_W'(WARMUP);
    localparam logic [CNT_W-1:0] STEP_CNT = CNT_W'(STRIDE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [RR_W-1:0]  RR_INIT  = RR_W'(N_REQ - 1);
    localparam sched_state_t     RESET_STATE = (WARMUP > 0) ? WARM : SERVE;
    localparam logic             RESET_BUSY  = (WARMUP > 0);

    sched_state_t      state;
    sched_state_t      state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [RR_W-1:0]   rr;
    logic [RR_W-1:0]   rr_next;
    logic [RR_W-1:0]   pick;
    logic              load;
    logic              step;
    logic [LFSR_W-1:0] load_val;

    // First set request searching upward from last+1 with wrap. The loop runs
    // from the farthest offset down so the nearest candidate is written last.
    function automatic logic [RR_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                input logic [RR_W-1:0]  last);
        logic [RR_W-1:0] sel;
        logic [RR_W-1:0] idx;
        sel = last;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = RR_W'((int'(last) + i) % N_REQ);
            if (r[idx]) sel = idx;
        end
        return sel;
    endfunction

    assign pick       = rr_pick(req, rr);
    assign data_valid = |gnt;

    lfsr16_core u_core (
        .clk      (clk),
        .nReset   (nReset),
        .load     (load),
        .load_val (load_val),
        .step     (step),
        .q        (data)
    );

    // State register: FSM state, step counter, round-robin pointer and busy flag.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            state <= RESET_STATE;
            cnt   <= WARM_CNT;
            rr    <= RR_INIT;
            busy  <= RESET_BUSY;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            rr    <= rr_next;
            busy  <= (state_next != SERVE);
        end
    end

    // Next-state logic: counter countdown, seed restart and grant bookkeeping.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        rr_next    = rr;
        case (state)
            WARM, STEP: begin
                cnt_next = cnt - CNT_ONE;
                if (cnt == CNT_ONE) state_next = SERVE;
            end
            SERVE: begin
                if (seed_valid) begin
                    if (WARMUP > 0) begin
                        state_next = WARM;
                        cnt_next   = WARM_CNT;
                    end
                end else if (|req) begin
                    rr_next = pick;
                    if (STRIDE > 1) begin
                        state_next = STEP;
                        cnt_next   = STEP_CNT;
                    end
                end
            end
            default: state_next = SERVE;
        endcase
    end

    // Outputs: grant pulse, seed handshake and LFSR load/step controls.
    always_comb begin
        gnt        = '0;
        seed_ready = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        // An all-zero seed would lock the LFSR up, so substitute the default.
        load_val   = (seed == '0) ? DEFAULT_SEED : seed;
        case (state)
            WARM, STEP: begin
                step = 1'b1;
            end
            SERVE: begin
                seed_ready = 1'b1;
                if (seed_valid) begin
                    load = 1'b1;
                end else if (|req) begin
                    gnt[pick] = 1'b1;
                    step      = 1'b1;
                end
            end
            default: begin
                step = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_lfsr_scheduler.sv
// Self-checking bench for lfsr_scheduler. Three instances with different
// WARMUP/STRIDE settings share one set of inputs; each is compared every cycle
// against a cycle-count/queue-free behavioural model, plus directed checks.
module tb_lfsr_scheduler;

    logic        clk;
    logic        nReset;
    logic        seed_valid;
    logic [15:0] seed;
    logic [3:0]  req;

    logic [2:0]       seed_ready_v;
    logic [2:0][3:0]  gnt_v;
    logic [2:0]       data_valid_v;
    logic [2:0][15:0] data_v;
    logic [2:0]       busy_v;

    int n_tests = 0;
    int n_fail  = 0;

    // Configurations: 0 = (W0,S1), 1 = (W0,S2), 2 = (W16,S1)
    int    cfg_warm   [3] = '{0, 0, 16};
    int    cfg_stride [3] = '{1, 2, 1};
    string cfg_name   [3] = '{"w0s1", "w0s2", "w16s1"};

    // Model state: current word, cycles left before serving resumes, last grantee
    logic [15:0] m_lfsr [3];
    int          m_wait [3];
    int          m_last [3];

    logic [3:0]  obs_gnt  [3];
    logic [15:0] obs_data [3];
    logic        obs_busy [3];

    lfsr_scheduler #(.N_REQ(4), .WARMUP(0), .STRIDE(1)) u_a (
        .clk(clk), .nReset(nReset), .seed_valid(seed_valid), .seed(seed),
        .seed_ready(seed_ready_v[0]), .req(req), .gnt(gnt_v[0]),
        .data_valid(data_valid_v[0]), .data(data_v[0]), .busy(busy_v[0]));

    lfsr_scheduler #(.N_REQ(4), .WARMUP(0), .STRIDE(2)) u_b (
        .clk(clk), .nReset(nReset), .seed_valid(seed_valid), .seed(seed),
        .seed_ready(seed_ready_v[1]), .req(req), .gnt(gnt_v[1]),
        .data_valid(data_valid_v[1]), .data(data_v[1]), .busy(busy_v[1]));

    lfsr_scheduler #(.N_REQ(4), .WARMUP(16), .STRIDE(1)) u_c (
        .clk(clk), .nReset(nReset), .seed_valid(seed_valid), .seed(seed),
        .seed_ready(seed_ready_v[2]), .req(req), .gnt(gnt_v[2]),
        .data_valid(data_valid_v[2]), .data(data_v[2]), .busy(busy_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] tb_next(input logic [15:0] q);
        return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    endfunction

    function automatic logic [15:0] succ(input logic [15:0] q, input int n);
        logic [15:0] v;
        v = q;
        for (int i = 0; i < n; i++) v = tb_next(v);
        return v;
    endfunction

    // One clock cycle: drive inputs, compare against the model, advance the model.
    task automatic cycle(input logic rn, input logic sv, input logic [15:0] sd, input logic [3:0] rq);
        logic [3:0]  e_gnt;
        logic        e_sr;
        logic        e_busy;
        int          idx;
        nReset     = rn;
        seed_valid = sv;
        seed       = sd;
        req        = rq;
        #2;
        for (int k = 0; k < 3; k++) begin
            obs_gnt[k]  = gnt_v[k];
            obs_data[k] = data_v[k];
            obs_busy[k] = busy_v[k];
            if (!rn) begin
                m_lfsr[k] = 16'hACE1;
                m_wait[k] = cfg_warm[k];
                m_last[k] = 3;
            end else begin
                e_gnt  = 4'b0000;
                e_sr   = (m_wait[k] == 0);
                e_busy = (m_wait[k] > 0);
                idx    = -1;
                if (m_wait[k] == 0 && !sv && rq != 4'b0000) begin
                    for (int off = 1; off <= 4; off++) begin
                        if (idx < 0 && rq[(m_last[k] + off) % 4]) idx = (m_last[k] + off) % 4;
                    end
                    e_gnt = 4'b0001 << idx;
                end
                check($sformatf("%s gnt", cfg_name[k]), 32'(gnt_v[k]), 32'(e_gnt));
                check($sformatf("%s data_valid", cfg_name[k]), 32'(data_valid_v[k]), 32'(e_gnt != 0));
                check($sformatf("%s seed_ready", cfg_name[k]), 32'(seed_ready_v[k]), 32'(e_sr));
                check($sformatf("%s busy", cfg_name[k]), 32'(busy_v[k]), 32'(e_busy));
                if (e_gnt != 0)
                    check($sformatf("%s data", cfg_name[k]), 32'(data_v[k]), 32'(m_lfsr[k]));
                if (m_wait[k] > 0) begin
                    m_lfsr[k] = tb_next(m_lfsr[k]);
                    m_wait[k] = m_wait[k] - 1;
                end else if (sv) begin
                    m_lfsr[k] = (sd == 16'h0000) ? 16'hACE1 : sd;
                    m_wait[k] = cfg_warm[k];
                end else if (idx >= 0) begin
                    m_last[k] = idx;
                    m_lfsr[k] = tb_next(m_lfsr[k]);
                    m_wait[k] = cfg_stride[k] - 1;
                end
            end
        end
        @(negedge clk);
    endtask

    // Hold a request and report the cycle offset and word of config k's first grant.
    task automatic first_grant(input int k, input logic [3:0] rq, output int at, output logic [15:0] d);
        at = -1;
        d  = 16'h0000;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1'b0, 16'h0000, rq);
            if (at < 0 && obs_gnt[k] != 4'b0000) begin
                at = i;
                d  = obs_data[k];
            end
        end
    endtask

    initial begin
        int          at;
        logic [15:0] d;
        logic [3:0]  rq;
        logic        rn;
        logic        sv;
        logic [15:0] sd;

        nReset     = 1'b0;
        seed_valid = 1'b0;
        seed       = 16'h0000;
        req        = 4'b0000;
        @(negedge clk);

        // Reset state and back-to-back / stride data
        cycle(1'b0, 1'b0, 16'h0000, 4'b0000);
        cycle(1'b1, 1'b0, 16'h0000, 4'b0000);
        check("reset data", 32'(obs_data[0]), 32'h0000ACE1);
        check("reset busy w0", 32'(obs_busy[0]), 32'd0);
        check("reset busy w16", 32'(obs_busy[2]), 32'd1);
        cycle(1'b1, 1'b0, 16'h0000, 4'b0001);
        check("b2b gnt0", 32'(obs_gnt[0]), 32'h1);
        check("b2b data0", 32'(obs_data[0]), 32'h0000ACE1);
        check("stride data0", 32'(obs_data[1]), 32'h0000ACE1);
        cycle(1'b1, 1'b0, 16'h0000, 4'b0001);
        check("b2b data1", 32'(obs_data[0]), 32'h000059C3);
        check("stride idle gnt", 32'(obs_gnt[1]), 32'h0);
        check("stride idle busy", 32'(obs_busy[1]), 32'd1);
        cycle(1'b1, 1'b0, 16'h0000, 4'b0001);
        check("b2b data2", 32'(obs_data[0]), 32'h0000B387);
        check("stride gnt1", 32'(obs_gnt[1]), 32'h1);
        check("stride data1", 32'(obs_data[1]), 32'h0000B387);

        // Round-robin order 0,1,2,3,0
        cycle(1'b0, 1'b0, 16'h0000, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 16'h0000, 4'b1111);
            check($sformatf("rr order %0d", i), 32'(obs_gnt[0]), 32'(4'b0001 << (i % 4)));
        end

        // Zero seed has priority over a request and maps to the default seed
        cycle(1'b0, 1'b0, 16'h0000, 4'b0000);
        cycle(1'b1, 1'b1, 16'h0000, 4'b0100);
        check("seed prio gnt", 32'(obs_gnt[0]), 32'h0);
        cycle(1'b1, 1'b0, 16'h0000, 4'b0100);
        check("zero seed gnt", 32'(obs_gnt[0]), 32'h4);
        check("zero seed data", 32'(obs_data[0]), 32'h0000ACE1);

        // Warm-up after reset
        cycle(1'b0, 1'b0, 16'h0000, 4'b0000);
        first_grant(2, 4'b0001, at, d);
        check("warm first grant cycle", 32'(at), 32'd16);
        check("warm first grant data", 32'(d), 32'(succ(16'hACE1, 16)));

        // Warm-up after seeding 0001
        cycle(1'b1, 1'b1, 16'h0001, 4'b0000);
        first_grant(2, 4'b0001, at, d);
        check("seed first grant cycle", 32'(at), 32'd16);
        check("seed first grant data", 32'(d), 32'(succ(16'h0001, 16)));

        // Reset during the 8th warm-up cycle restarts the full warm-up
        cycle(1'b0, 1'b0, 16'h0000, 4'b0000);
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 16'h0000, 4'b0001);
        cycle(1'b0, 1'b0, 16'h0000, 4'b0001);
        check("midwarm busy", 32'(busy_v[2]), 32'd1);
        first_grant(2, 4'b0001, at, d);
        check("midwarm first grant cycle", 32'(at), 32'd16);
        check("midwarm first grant data", 32'(d), 32'(succ(16'hACE1, 16)));

        // Randomized traffic against the model
        rq = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            rn = ($urandom_range(0, 199) != 0);
            sv = ($urandom_range(0, 15) == 0);
            sd = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
            cycle(rn, sv, sd, rq);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
